// File: rtl/step_ctrl.sv
// -----------------------------------------------------------------------------
// step_ctrl
//
// Run/halt and single-step controller for the MIPS core clock-enable.
//
// The raw step pushbutton (active-low) and the run switch come from board I/O
// and are asynchronous to clk. Each one is synchronized with two flops and
// then debounced. Edge detection on the debounced levels produces the
// one-cycle events that drive a four-state sequencer:
//   HALT  : processor frozen
//   STEP  : exactly one enabled cycle, then back to HALT
//   RUN   : enabled every cycle until run_fall or a breakpoint hit
//   BREAK : frozen on the breakpoint instruction (not executed)
//
// Ports
//   clk          processor clock; all logic on the rising edge
//   rst          asynchronous, active-low reset
//   step         raw step pushbutton, active-low (pressed = 0)
//   run_sw       raw run switch (1 = run)
//   bp_en        breakpoint enable (synchronous)
//   bp_addr      breakpoint address            [PC_WIDTH]
//   pc           current processor PC          [PC_WIDTH]
//   cnt_clr      synchronous clear of cycle_count
//   mips_en      processor clock-enable
//   halted       state is HALT or BREAK
//   at_break     state is BREAK
//   cycle_count  number of mips_en-high cycles [CNT_WIDTH], wraps
// -----------------------------------------------------------------------------
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PC_WIDTH        = 32,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 run_sw,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 cnt_clr,
  output logic                 mips_en,
  output logic                 halted,
  output logic                 at_break,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  // Channel 0 is the step button, channel 1 the run switch. Reset levels are
  // the idle levels of each input (button released = 1, switch off = 0) so no
  // spurious event appears when reset is released.
  localparam int             NCH     = 2;
  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NCH-1:0] RST_LVL = 2'b01;

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] w_db;     // debounced level
  logic [NCH-1:0] w_db_d;   // debounced level one cycle earlier

  assign w_raw = {run_sw, step};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_cond
      logic           r_s1;
      logic           r_s2;
      logic           r_db;
      logic           r_db_d;
      logic [DBW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s1   <= RST_LVL[gi];
          r_s2   <= RST_LVL[gi];
          r_db   <= RST_LVL[gi];
          r_db_d <= RST_LVL[gi];
          r_cnt  <= '0;
        end else begin
          r_s1   <= w_raw[gi];
          r_s2   <= r_s1;
          r_db_d <= r_db;
          // The counter only advances while the synchronized sample disagrees
          // with the accepted level; any agreeing sample restarts it, so a
          // level is accepted only after DEBOUNCE_CYCLES consecutive samples.
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + DBW'(1);
          end
        end
      end

      assign w_db[gi]   = r_db;
      assign w_db_d[gi] = r_db_d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Events
  // ---------------------------------------------------------------------------
  logic w_press;
  logic w_run_rise;
  logic w_run_fall;

  assign w_press    =  w_db_d[0] & ~w_db[0];   // button 1 -> 0
  assign w_run_rise = ~w_db_d[1] &  w_db[1];
  assign w_run_fall =  w_db_d[1] & ~w_db[1];

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_STEP  = 2'd1,
    S_RUN   = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_skip;
  logic   w_hit;

  // skip masks the breakpoint comparator for the first RUN cycle so a run
  // started while sitting on the breakpoint address makes progress.
  assign w_hit = bp_en & (pc == bp_addr) & ~r_skip;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HALT: begin
        // run_rise wins over a coincident press; that press is discarded.
        if (w_run_rise) begin
          w_state_next = S_RUN;
        end else if (w_press) begin
          w_state_next = S_STEP;
        end
      end
      S_STEP: begin
        w_state_next = S_HALT;
      end
      S_RUN: begin
        if (w_run_fall) begin
          w_state_next = S_HALT;
        end else if (w_hit) begin
          w_state_next = S_BREAK;
        end
      end
      S_BREAK: begin
        // A press executes the breakpoint instruction via STEP and then
        // parks in HALT; resuming RUN needs a fresh run_rise.
        if (w_run_fall) begin
          w_state_next = S_HALT;
        end else if (w_press) begin
          w_state_next = S_STEP;
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip <= 1'b0;
    end else if ((r_state != S_RUN) && (w_state_next == S_RUN)) begin
      r_skip <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_skip <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The enable is combinational on hit and run_fall so the processor is held
  // in the very cycle the breakpoint PC appears; the instruction at the
  // breakpoint is therefore not executed.
  assign mips_en  = (r_state == S_STEP) |
                    ((r_state == S_RUN) & ~w_hit & ~w_run_fall);
  assign halted   = (r_state == S_HALT) | (r_state == S_BREAK);
  assign at_break = (r_state == S_BREAK);

  // ---------------------------------------------------------------------------
  // Enabled-cycle counter (wraps; clear beats increment)
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_cycle_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_count <= '0;
    end else if (cnt_clr) begin
      r_cycle_count <= '0;
    end else if (mips_en) begin
      r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
    end
  end

  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_ctrl
//
// Scenario tasks drive the raw inputs one clock at a time (changes land 1 ns
// after the rising edge, outputs are sampled on the falling edge). The
// reference is expressed in terms of observable behaviour: number of enabled
// cycles per press / per run window, pulse widths, where the PC stops, and a
// modulo-2^CNT_WIDTH count of enabled cycles.
// -----------------------------------------------------------------------------
module tb_step_ctrl;

  localparam int DB = 4;
  localparam int PW = 8;
  localparam int CW = 4;
  localparam int SETTLE = 2 * DB + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step = 1'b1;
  logic          run_sw = 1'b0;
  logic          bp_en = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic [PW-1:0] pc = '0;
  logic          cnt_clr = 1'b0;
  logic          mips_en;
  logic          halted;
  logic          at_break;
  logic [CW-1:0] cycle_count;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PC_WIDTH(PW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step(step),
    .run_sw(run_sw),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc(pc),
    .cnt_clr(cnt_clr),
    .mips_en(mips_en),
    .halted(halted),
    .at_break(at_break),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-cycle samples and observation statistics
  logic          en_s;
  logic          halted_s;
  logic          brk_s;
  logic [PW-1:0] pc_s;
  int            model_cnt = 0;
  int            en_cycles = 0;
  int            pulses = 0;
  int            max_w = 0;
  int            cur_w = 0;
  logic          prev_en = 1'b0;
  logic          brk_seen = 1'b0;
  logic          first_en_seen = 1'b0;
  logic [PW-1:0] first_en_pc = '0;
  logic          pc_follow = 1'b0;

  // One clock: sample mid-cycle, update the reference, then let the bench
  // processor advance its PC if that cycle was enabled.
  task automatic tick();
    @(negedge clk);
    en_s     = mips_en;
    halted_s = halted;
    brk_s    = at_break;
    pc_s     = pc;
    if (en_s) begin
      en_cycles++;
      cur_w++;
      if (!prev_en) pulses++;
      if (cur_w > max_w) max_w = cur_w;
      if (!first_en_seen) begin
        first_en_seen = 1'b1;
        first_en_pc   = pc;
      end
    end else begin
      cur_w = 0;
    end
    if (brk_s) brk_seen = 1'b1;
    prev_en = en_s;
    if (cnt_clr)   model_cnt = 0;
    else if (en_s) model_cnt = (model_cnt + 1) % (1 << CW);
    @(posedge clk);
    #1;
    if (pc_follow && en_s) pc = pc + 8'd4;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    en_cycles     = 0;
    pulses        = 0;
    max_w         = 0;
    cur_w         = 0;
    brk_seen      = 1'b0;
    first_en_seen = 1'b0;
  endtask

  // Bouncy press: short opposite-level glitches at both edges, held for
  // 'hold' cycles, then released and left to settle.
  task automatic press(input int hold);
    int nb;
    nb = int'($urandom_range(1, 3));
    for (int b = 0; b < nb; b++) begin
      step = 1'b0; ticks(int'($urandom_range(1, 2)));
      step = 1'b1; ticks(int'($urandom_range(1, 2)));
    end
    step = 1'b0;
    ticks(hold);
    nb = int'($urandom_range(1, 3));
    for (int b = 0; b < nb; b++) begin
      step = 1'b1; ticks(int'($urandom_range(1, 2)));
      step = 1'b0; ticks(int'($urandom_range(1, 2)));
    end
    step = 1'b1;
    ticks(SETTLE);
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; step = 1'b1; run_sw = 1'b0;
    #2;
    total++; if (mips_en !== 1'b0)  begin bad++; $display("FAIL reset_en got=%b want=0", mips_en); end
    total++; if (halted !== 1'b1)   begin bad++; $display("FAIL reset_halted got=%b want=1", halted); end
    total++; if (at_break !== 1'b0) begin bad++; $display("FAIL reset_break got=%b want=0", at_break); end
    total++; if (cycle_count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
    ticks(3);
    rst = 1'b1;
    model_cnt = 0;

    // Into RUN, then reset asynchronously in mid-cycle.
    run_sw = 1'b1;
    ticks(15);
    total++; if (en_s !== 1'b1) begin bad++; $display("FAIL midrun_en got=%b want=1", en_s); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (mips_en !== 1'b0)  begin bad++; $display("FAIL async_rst_en got=%b want=0", mips_en); end
    total++; if (halted !== 1'b1)   begin bad++; $display("FAIL async_rst_halted got=%b want=1", halted); end
    total++; if (at_break !== 1'b0) begin bad++; $display("FAIL async_rst_break got=%b want=0", at_break); end
    total++; if (cycle_count !== '0) begin bad++; $display("FAIL async_rst_count got=%0d want=0", cycle_count); end
    run_sw = 1'b0;
    ticks(2);
    rst = 1'b1;
    model_cnt = 0;
    clear_stats();
    ticks(100);
    total++; if (en_cycles !== 0) begin bad++; $display("FAIL idle_en_cycles got=%0d want=0", en_cycles); end
    total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL idle_count got=%0d want=%0d", cycle_count, model_cnt); end
    $display("reset: idle en_cycles=%0d count=%0d", en_cycles, cycle_count);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_step();
    int hold;
    clear_count();
    for (int i = 0; i < 6; i++) begin
      hold = (i == 0) ? 50 : int'($urandom_range(8, 40));
      clear_stats();
      press(hold);
      total++; if (pulses !== 1) begin bad++; $display("FAIL step%0d_pulses got=%0d want=1", i, pulses); end
      total++; if (max_w !== 1)  begin bad++; $display("FAIL step%0d_width got=%0d want=1", i, max_w); end
      total++; if (halted_s !== 1'b1 || brk_s !== 1'b0) begin bad++; $display("FAIL step%0d_state halted=%b break=%b want 1/0", i, halted_s, brk_s); end
      if (i == 2) begin
        total++; if (cycle_count !== 4'd3) begin bad++; $display("FAIL step_count3 got=%0d want=3", cycle_count); end
      end
      $display("step %0d: hold=%0d pulses=%0d width=%0d count=%0d", i, hold, pulses, max_w, cycle_count);
    end
    total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL step_count got=%0d want=%0d", cycle_count, model_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  // Run window of H cycles: run_rise and run_fall share the same latency, so
  // they are H cycles apart and the enabled cycles are the H-1 between them.
  task automatic test_run();
    int h;
    bp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      h = (i == 0) ? 21 : int'($urandom_range(6, 30));
      clear_stats();
      run_sw = 1'b1;
      ticks(h);
      run_sw = 1'b0;
      ticks(SETTLE);
      total++; if (en_cycles !== h - 1) begin bad++; $display("FAIL run%0d_cycles got=%0d want=%0d", i, en_cycles, h - 1); end
      total++; if (pulses !== 1) begin bad++; $display("FAIL run%0d_contig got=%0d want=1", i, pulses); end
      total++; if (halted_s !== 1'b1) begin bad++; $display("FAIL run%0d_halted got=%b want=1", i, halted_s); end
      total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL run%0d_count got=%0d want=%0d", i, cycle_count, model_cnt); end
      $display("run %0d: high=%0d en_cycles=%0d count=%0d", i, h, en_cycles, cycle_count);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_breakpoint();
    int hit_idx;
    int brk_idx;
    logic hit_en;
    bp_en = 1'b1; bp_addr = 8'h40; pc = 8'h30; pc_follow = 1'b1;
    hit_idx = -1; brk_idx = -1; hit_en = 1'b1;
    clear_stats();
    run_sw = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pc_s == 8'h40 && hit_idx < 0) begin
        hit_idx = i;
        hit_en  = en_s;
      end
      if (brk_s) begin
        brk_idx = i;
        break;
      end
    end
    total++; if (brk_idx < 0) begin bad++; $display("FAIL bp_timeout no at_break within 60 cycles"); end
    total++; if (hit_en !== 1'b0) begin bad++; $display("FAIL bp_en_at_hit got=%b want=0", hit_en); end
    total++; if (hit_idx < 0 || brk_idx !== hit_idx + 1) begin bad++; $display("FAIL bp_latency hit=%0d break=%0d want break=hit+1", hit_idx, brk_idx); end
    total++; if (en_cycles !== 4) begin bad++; $display("FAIL bp_run_cycles got=%0d want=4", en_cycles); end
    ticks(5);
    total++; if (pc !== 8'h40 || brk_s !== 1'b1) begin bad++; $display("FAIL bp_hold pc=%h break=%b want 40/1", pc, brk_s); end
    $display("breakpoint: hit_idx=%0d break_idx=%0d pc=%h", hit_idx, brk_idx, pc);

    clear_stats();
    press(int'($urandom_range(8, 20)));
    total++; if (en_cycles !== 1) begin bad++; $display("FAIL bp_step_cycles got=%0d want=1", en_cycles); end
    total++; if (halted_s !== 1'b1 || brk_s !== 1'b0) begin bad++; $display("FAIL bp_step_state halted=%b break=%b want 1/0", halted_s, brk_s); end
    total++; if (pc !== 8'h44) begin bad++; $display("FAIL bp_step_pc got=%h want=44", pc); end
    run_sw = 1'b0;
    ticks(SETTLE);
    total++; if (en_cycles !== 1) begin bad++; $display("FAIL bp_after_fall got=%0d want=1", en_cycles); end
    total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL bp_count got=%0d want=%0d", cycle_count, model_cnt); end
    $display("breakpoint step: en_cycles=%0d pc=%h", en_cycles, pc);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_run_from_bp();
    bp_en = 1'b1; bp_addr = 8'h40; pc = 8'h40; pc_follow = 1'b1;
    clear_stats();
    run_sw = 1'b1;
    ticks(12);
    run_sw = 1'b0;
    ticks(SETTLE);
    total++; if (first_en_seen !== 1'b1 || first_en_pc !== 8'h40) begin bad++; $display("FAIL rfb_first seen=%b pc=%h want 1/40", first_en_seen, first_en_pc); end
    total++; if (en_cycles !== 11) begin bad++; $display("FAIL rfb_cycles got=%0d want=11", en_cycles); end
    total++; if (brk_seen !== 1'b0) begin bad++; $display("FAIL rfb_break got=%b want=0", brk_seen); end
    total++; if (pc !== 8'h6C) begin bad++; $display("FAIL rfb_pc got=%h want=6c", pc); end
    $display("run from bp: en_cycles=%0d pc=%h", en_cycles, pc);
    pc_follow = 1'b0;
    bp_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    bp_en = 1'b0;
    clear_stats();
    step = 1'b0;
    run_sw = 1'b1;
    ticks(10);
    run_sw = 1'b0;
    ticks(SETTLE);
    step = 1'b1;
    ticks(SETTLE);
    total++; if (en_cycles !== 9) begin bad++; $display("FAIL simul_cycles got=%0d want=9", en_cycles); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL simul_pulses got=%0d want=1", pulses); end
    total++; if (halted_s !== 1'b1) begin bad++; $display("FAIL simul_halted got=%b want=1", halted_s); end
    $display("simultaneous: en_cycles=%0d pulses=%0d", en_cycles, pulses);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap_clear();
    clear_count();
    total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL clr_idle got=%0d want=0", cycle_count); end
    clear_stats();
    run_sw = 1'b1;
    ticks(18);
    run_sw = 1'b0;
    ticks(SETTLE);
    total++; if (en_cycles !== 17) begin bad++; $display("FAIL wrap_cycles got=%0d want=17", en_cycles); end
    total++; if (cycle_count !== 4'd1) begin bad++; $display("FAIL wrap_count got=%0d want=1", cycle_count); end
    $display("wrap: en_cycles=%0d count=%0d", en_cycles, cycle_count);

    run_sw = 1'b1;
    ticks(10 + int'($urandom_range(0, 5)));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++; if (en_s !== 1'b1) begin bad++; $display("FAIL clr_en_active got=%b want=1", en_s); end
    total++; if (cycle_count !== 4'd0) begin bad++; $display("FAIL clr_running got=%0d want=0", cycle_count); end
    ticks(3);
    total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL clr_resume got=%0d want=%0d", cycle_count, model_cnt); end
    run_sw = 1'b0;
    ticks(SETTLE);
    total++; if (cycle_count !== 4'(model_cnt)) begin bad++; $display("FAIL clr_final got=%0d want=%0d", cycle_count, model_cnt); end
    $display("clear while enabled: count=%0d", cycle_count);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_step();
    test_run();
    test_breakpoint();
    test_run_from_bp();
    test_simultaneous();
    test_wrap_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
